snake_scan_engine: RTL and testbench
====================================

// Module: snake_scan_engine
// PURPOSE
//  Parametrised successor of the 8x8 scanned-matrix snake demo. Moves a snake of
//  run-time-selectable length around the perimeter of a ROWS x COLS LED matrix.
//  Supports forward/reverse direction and pause, and drives row-scan and column
//  planes directly. The head is drawn on its own colour plane, separate from the body.
//  Sits between the board clock and the matrix driver pins; replaces the fixed
//  4-segment, 24-cell version.
// PARAMETERS
//  ROWS      8   matrix rows; turn width
//  COLS      8   matrix columns; display width = 2*COLS
//  MAX_LEN   8   segment registers implemented (max snake length)
//  STEP_DIV  16  clock cycles per snake step (>=2)
//  localparam PATH_LEN = 2*(ROWS+COLS)-4; POS_W = $clog2(PATH_LEN)
// PORTS
//  clock     in   1          single system clock, all logic on posedge
//  reset     in   1          synchronous, active-low
//  enable    in   1          1 = snake moves; 0 = paused (scan continues)
//  dir       in   1          0 = forward (pos+1), 1 = reverse (pos-1)
//  len_sel   in   4          snake length; 0 -> 1, >MAX_LEN -> MAX_LEN
//  turn      out  ROWS       one-hot row select
//  display   out  2*COLS     {head plane[COLS-1:0], body plane[COLS-1:0]}; bit c = column c
//  head_pos  out  POS_W      current head path position
//  wrap      out  1          one-cycle pulse on the step where the head crosses 0/PATH_LEN-1
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - turn=1, display=0, head_pos=0, wrap=0, all seg[i]=0, divider=0.
//   - Reset has priority over every event in the same cycle; a step due that cycle is dropped.
//  Scan:
//   - Every cycle, turn rotates left one-hot: bit ROWS-1 -> bit 0. Independent of enable.
//  Display:
//   - Registered, updated on the same edge as turn. Shows the row selected by the
//     NEW turn value, built from the NEW segment positions (zero-cycle skew).
//   - Head plane: column of seg[0] if its row matches.
//   - Body plane: OR of columns of seg[1..L-1] whose row matches, L = clamped len_sel.
//   - Overlapping segments OR together.
//   - Segments with index >= L are still shifted but never drawn.
//  Step divider:
//   - Counts 0..STEP_DIV-1 while enable=1; holds its value while enable=0.
//   - Step fires on the cycle the count is STEP_DIV-1 (count returns to 0).
//  Step:
//   - seg[0] <= forward ? (pos==PATH_LEN-1 ? 0 : pos+1) : (pos==0 ? PATH_LEN-1 : pos-1).
//   - seg[i] <= seg[i-1] for i=1..MAX_LEN-1. Shifting also happens on wrap.
//   - head_pos mirrors seg[0].
//   - wrap=1 for exactly that cycle when the head crosses 0/PATH_LEN-1, else 0.
//  dir and len_sel:
//   - Sampled each cycle. dir takes effect at the next step; the head reverses in
//     place and the body retraces itself.
//   - A len_sel change affects drawing on the next display update.
//  Path map (clockwise perimeter from row0, col0):
//   - p in 0..COLS-1                     -> (row 0, col p)
//   - p in COLS..COLS+ROWS-2             -> (row p-COLS+1, col COLS-1)
//   - next COLS-1 positions              -> row ROWS-1, col COLS-2 down to 0
//   - final ROWS-2 positions             -> col 0, row ROWS-2 down to 1
//   - p >= PATH_LEN                      -> invalid, never drawn
// STRUCTURE
//  snake_pkg:
//   - path-length/width functions.
//   - plane index constants HEAD_PLANE=1, BODY_PLANE=0.
//  Sub-module snake_path_map:
//   - combinational pos -> {valid, row one-hot, col one-hot}.
//   - instantiated MAX_LEN times, one per segment register.
//  Top level: divider, segment shift register, row ring counter, plane OR-reduce.
// TESTING (defaults unless stated; STEP_DIV=4 where noted)
//  1 Reset: reset=0 for 3 cycles
//    -> turn=8'h01, display=16'h0000, head_pos=0, wrap=0.
//  2 Scan: enable=0, reset released
//    -> turn 01,02,04,..,80,01 over 9 cycles; head_pos stays 0.
//  3 Move (STEP_DIV=4): enable=1, dir=0, len_sel=4, run 20 cycles
//    -> head_pos=5; in row 0 display={8'b0010_0000, 8'b0001_1100}.
//  4 Forward wrap: head at 27 with body 26,25,24, next step
//    -> head_pos=0, wrap high for exactly 1 cycle;
//       row 0 head plane 8'h01; body at (row1,col0), (row2,col0), (row3,col0).
//  5 Reverse/clamp: dir=1 at head 0, len_sel=15
//    -> head_pos=27, wrap pulses once; body drawn with L=8 (segments 1..7).
//  6 Pause/reset mid-run: enable=0 for 3*STEP_DIV cycles -> head_pos frozen, turn keeps rotating;
//    reset=0 on the step cycle -> no step, all outputs at reset values next cycle.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants and sizing helpers for the perimeter snake engine.
package snake_pkg;

    localparam int HEAD_PLANE = 1;
    localparam int BODY_PLANE = 0;

    function automatic int path_len(input int rows, input int cols);
        return 2 * (rows + cols) - 4;
    endfunction

    function automatic int pos_w(input int rows, input int cols);
        return $clog2(path_len(rows, cols));
    endfunction

endpackage

// File: rtl/snake_path_map.sv
// Combinational map from a clockwise perimeter position to one-hot row/column.
module snake_path_map #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int PATH_LEN = 28,
    parameter int POS_W    = 5
) (
    input  logic [POS_W-1:0] pos,
    output logic             valid,
    output logic [ROWS-1:0]  row_oh,
    output logic [COLS-1:0]  col_oh
);

    int p_i;
    int r_i;
    int c_i;

    // Walk: top row rightwards, right column down, bottom row leftwards, left column up.
    always_comb begin
        p_i   = int'(pos);
        valid = 1'b1;
        r_i   = 0;
        c_i   = 0;
        if (p_i < COLS) begin
            r_i = 0;
            c_i = p_i;
        end else if (p_i <= COLS + ROWS - 2) begin
            r_i = p_i - COLS + 1;
            c_i = COLS - 1;
        end else if (p_i <= 2 * COLS + ROWS - 3) begin
            r_i = ROWS - 1;
            c_i = COLS - 2 - (p_i - (COLS + ROWS - 1));
        end else if (p_i < PATH_LEN) begin
            r_i = ROWS - 2 - (p_i - (2 * COLS + ROWS - 2));
            c_i = 0;
        end else begin
            valid = 1'b0;
        end
        row_oh = valid ? (ROWS'(1) << r_i) : '0;
        col_oh = valid ? (COLS'(1) << c_i) : '0;
    end

endmodule

// File: rtl/snake_scan_engine.sv
// Perimeter snake on a scanned ROWS x COLS matrix: step divider, segment shift
// register, row ring counter and separate head/body column planes.
module snake_scan_engine
    import snake_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int MAX_LEN  = 8,
    parameter int STEP_DIV = 16,
    localparam int PATH_LEN = path_len(ROWS, COLS),
    localparam int POS_W    = pos_w(ROWS, COLS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              dir,
    input  logic [3:0]        len_sel,
    output logic [ROWS-1:0]   turn,
    output logic [2*COLS-1:0] display,
    output logic [POS_W-1:0]  head_pos,
    output logic              wrap
);

    localparam int DIV_W = $clog2(STEP_DIV);

    logic [DIV_W-1:0]    div_q, div_d;
    logic [POS_W-1:0]    seg_q [MAX_LEN];
    logic [POS_W-1:0]    seg_d [MAX_LEN];
    logic [ROWS-1:0]     turn_q, turn_d;
    logic [2*COLS-1:0]   display_q, display_d;
    logic                wrap_q, wrap_d;
    logic                step;
    int                  len_eff;

    logic                seg_valid [MAX_LEN];
    logic [ROWS-1:0]     seg_row   [MAX_LEN];
    logic [COLS-1:0]     seg_col   [MAX_LEN];
    logic [COLS-1:0]     head_plane, body_plane;

    always_comb begin
        step   = enable && (div_q == DIV_W'(STEP_DIV - 1));
        div_d  = div_q;
        if (enable) begin
            div_d = step ? '0 : div_q + DIV_W'(1);
        end
        turn_d = {turn_q[ROWS-2:0], turn_q[ROWS-1]};
    end

    always_comb begin
        wrap_d = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            seg_d[i] = seg_q[i];
        end
        if (step) begin
            if (dir) begin
                seg_d[0] = (seg_q[0] == '0) ? POS_W'(PATH_LEN - 1) : seg_q[0] - POS_W'(1);
                wrap_d   = (seg_q[0] == '0);
            end else begin
                seg_d[0] = (seg_q[0] == POS_W'(PATH_LEN - 1)) ? '0 : seg_q[0] + POS_W'(1);
                wrap_d   = (seg_q[0] == POS_W'(PATH_LEN - 1));
            end
            for (int i = 1; i < MAX_LEN; i++) begin
                seg_d[i] = seg_q[i-1];
            end
        end
    end

    // Map the next-state positions so the registered display matches the new turn.
    for (genvar g = 0; g < MAX_LEN; g++) begin : g_map
        snake_path_map #(
            .ROWS     (ROWS),
            .COLS     (COLS),
            .PATH_LEN (PATH_LEN),
            .POS_W    (POS_W)
        ) u_map (
            .pos    (seg_d[g]),
            .valid  (seg_valid[g]),
            .row_oh (seg_row[g]),
            .col_oh (seg_col[g])
        );
    end

    always_comb begin
        if (len_sel == 4'd0) begin
            len_eff = 1;
        end else if (int'(len_sel) > MAX_LEN) begin
            len_eff = MAX_LEN;
        end else begin
            len_eff = int'(len_sel);
        end

        head_plane = '0;
        body_plane = '0;
        if (seg_valid[0] && ((seg_row[0] & turn_d) != '0)) begin
            head_plane = seg_col[0];
        end
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((i < len_eff) && seg_valid[i] && ((seg_row[i] & turn_d) != '0)) begin
                body_plane = body_plane | seg_col[i];
            end
        end

        display_d = '0;
        display_d[HEAD_PLANE*COLS +: COLS] = head_plane;
        display_d[BODY_PLANE*COLS +: COLS] = body_plane;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            div_q     <= '0;
            turn_q    <= ROWS'(1);
            display_q <= '0;
            wrap_q    <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_q[i] <= '0;
            end
        end else begin
            div_q     <= div_d;
            turn_q    <= turn_d;
            display_q <= display_d;
            wrap_q    <= wrap_d;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_q[i] <= seg_d[i];
            end
        end
    end

    assign turn     = turn_q;
    assign display  = display_q;
    assign head_pos = seg_q[0];
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_snake_scan_engine.sv
// Scoreboard bench: a perimeter-walk reference model predicts every cycle's outputs.
module tb_snake_scan_engine;

    localparam int ROWS    = 8;
    localparam int COLS    = 8;
    localparam int MAX_LEN = 8;
    localparam int SD      = 4;
    localparam int P       = 2 * (ROWS + COLS) - 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        dir = 1'b0;
    logic [3:0]  len_sel = 4'd0;
    logic [7:0]  turn;
    logic [15:0] display;
    logic [4:0]  head_pos;
    logic        wrap;

    snake_scan_engine #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .MAX_LEN  (MAX_LEN),
        .STEP_DIV (SD)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .dir      (dir),
        .len_sel  (len_sel),
        .turn     (turn),
        .display  (display),
        .head_pos (head_pos),
        .wrap     (wrap)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0]  turn;
        logic [15:0] disp;
        logic [4:0]  hp;
        logic        wrap;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pr[P];
    int   pc[P];
    int   m_row;
    int   m_div;
    int   m_seg[MAX_LEN];
    int   exp_wraps = 0;
    int   dut_wraps = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model(input logic rst_n, input logic en, input logic d, input logic [3:0] ls);
        exp_t e;
        int   len;
        bit   stp;
        e.wrap = 1'b0;
        e.disp = '0;
        if (!rst_n) begin
            m_row = 0;
            m_div = 0;
            for (int i = 0; i < MAX_LEN; i++) m_seg[i] = 0;
        end else begin
            m_row = (m_row + 1) % ROWS;
            stp   = en && (m_div == SD - 1);
            if (en) m_div = (m_div + 1) % SD;
            if (stp) begin
                e.wrap = d ? (m_seg[0] == 0) : (m_seg[0] == P - 1);
                for (int i = MAX_LEN - 1; i > 0; i--) m_seg[i] = m_seg[i-1];
                m_seg[0] = d ? (m_seg[0] + P - 1) % P : (m_seg[0] + 1) % P;
            end
            len = (ls == 0) ? 1 : ((int'(ls) > MAX_LEN) ? MAX_LEN : int'(ls));
            for (int i = 0; i < len; i++) begin
                if (pr[m_seg[i]] == m_row) begin
                    if (i == 0) e.disp[COLS + pc[m_seg[i]]] = 1'b1;
                    else        e.disp[pc[m_seg[i]]] = 1'b1;
                end
            end
        end
        e.turn = 8'(1 << m_row);
        e.hp   = 5'(m_seg[0]);
        if (e.wrap) exp_wraps++;
        q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic e, input logic d, input logic [3:0] l);
        reset   = r;
        enable  = e;
        dir     = d;
        len_sel = l;
        model(r, e, d, l);
        @(posedge clock);
        #1;
    endtask

    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk("turn", 32'(turn), 32'(mon_e.turn));
                chk("display", 32'(display), 32'(mon_e.disp));
                chk("head_pos", 32'(head_pos), 32'(mon_e.hp));
                chk("wrap", 32'(wrap), 32'(mon_e.wrap));
                if (wrap === 1'b1) dut_wraps++;
            end
        end
    end

    initial begin
        int r;
        int c;
        int n;
        int hold;
        r = 0;
        c = 0;
        for (int p = 0; p < P; p++) begin
            pr[p] = r;
            pc[p] = c;
            if (r == 0 && c < COLS - 1)             c++;
            else if (c == COLS - 1 && r < ROWS - 1) r++;
            else if (r == ROWS - 1 && c > 0)        c--;
            else                                    r--;
        end

        // reset held low
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 4'd4);
        chk("reset_turn", 32'(turn), 32'h01);
        chk("reset_display", 32'(display), 32'h0000);
        chk("reset_head", 32'(head_pos), 32'd0);
        chk("reset_wrap", 32'(wrap), 32'd0);

        // scan while paused
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0, 4'd4);
        chk("scan_head", 32'(head_pos), 32'd0);
        chk("scan_turn", 32'(turn), 32'h02);

        // movement
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0, 4'd4);
        chk("move_head", 32'(head_pos), 32'd5);
        n = 0;
        while (m_row != 0 && n < 16) begin
            cyc(1'b1, 1'b0, 1'b0, 4'd4);
            n++;
        end
        chk("move_row0_turn", 32'(turn), 32'h01);
        chk("move_row0_display", 32'(display), 32'h201C);

        // forward wrap
        n = 0;
        while (m_seg[0] != P - 1 && n < 200) begin
            cyc(1'b1, 1'b1, 1'b0, 4'd4);
            n++;
        end
        n = 0;
        while (m_seg[0] != 0 && n < 10) begin
            cyc(1'b1, 1'b1, 1'b0, 4'd4);
            n++;
        end
        chk("fwd_wrap_head", 32'(head_pos), 32'd0);
        chk("fwd_wrap_pulse", 32'(wrap), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 4'd4);
        chk("fwd_wrap_single", 32'(wrap), 32'd0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 4'd4);

        // reverse with clamped length
        n = 0;
        while (m_seg[0] != P - 1 && n < 10) begin
            cyc(1'b1, 1'b1, 1'b1, 4'd15);
            n++;
        end
        chk("rev_wrap_head", 32'(head_pos), 32'd27);
        chk("rev_wrap_pulse", 32'(wrap), 32'd1);
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'b1, 4'd15);

        // pause then reset on a step cycle
        hold = m_seg[0];
        for (int i = 0; i < 3 * SD; i++) cyc(1'b1, 1'b0, 1'b1, 4'd6);
        chk("pause_head", 32'(head_pos), 32'(hold));
        n = 0;
        while (m_div != SD - 1 && n < 8) begin
            cyc(1'b1, 1'b1, 1'b0, 4'd6);
            n++;
        end
        cyc(1'b0, 1'b1, 1'b0, 4'd6);
        chk("stepreset_head", 32'(head_pos), 32'd0);
        chk("stepreset_turn", 32'(turn), 32'h01);
        chk("stepreset_display", 32'(display), 32'h0000);
        chk("stepreset_wrap", 32'(wrap), 32'd0);

        // randomized run
        begin
            logic rd;
            rd = 1'b0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 19) == 0) rd = ~rd;
                cyc(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) != 0), rd,
                    4'($urandom_range(0, 15)));
            end
        end

        @(negedge clock);
        @(negedge clock);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("wrap_count", 32'(dut_wraps), 32'(exp_wraps));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
